// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned HDR_W      = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_STEP  = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // master is the loader itself; slave is the byte source plus the RAM.
    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes little-endian into one instruction word and flags the last byte.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_accept,
    input  logic [7:0]              i_data,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_full
);
    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]        r_cnt;
    logic [8*WORD_BYTES-1:0] r_word;

    assign o_word_full = i_accept && (r_cnt == CNT_W'(WORD_BYTES - 1));
    assign o_word      = r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_data;
            r_cnt                        <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted byte stream into instruction RAM and holds the CPU until it completes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.master    bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [HDR_W-1:0] words_loaded
);

    state_t            r_state;
    state_t            w_next;
    logic              w_in_ready;
    logic              w_start_load;
    logic              w_byte_accept;
    logic              w_word_full;
    logic [7:0]        r_hdr_lo;
    logic [HDR_W-1:0]  r_nwords;
    logic [HDR_W-1:0]  r_words;
    logic [HDR_W-1:0]  w_hdr_count;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LAST_STATE = CSUM;
    logic [7:0] r_xor;
`else
    localparam state_t LAST_STATE = DONE;
`endif

    assign w_hdr_count   = {bus.in_data, r_hdr_lo};
    assign w_byte_accept = (r_state == LOAD) && bus.in_valid;

    imem_loader_byte_assembler u_assembler (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start_load),
        .i_accept    (w_byte_accept),
        .i_data      (bus.in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_in_ready   = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_next       = HDR0;
                    w_start_load = 1'b1;
                end
            end
            HDR0: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = HDR1;
            end
            HDR1: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_hdr_count == '0)
                        w_next = LAST_STATE;
                    else if (32'(w_hdr_count) > MAX_WORDS)
                        w_next = ERROR;
                    else
                        w_next = LOAD;
                end
            end
            LOAD: begin
                w_in_ready = 1'b1;
                if (w_word_full) w_next = WRITE;
            end
            WRITE: begin
                w_next = (r_words + HDR_W'(1) < r_nwords) ? LOAD : LAST_STATE;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = (bus.in_data == r_xor) ? DONE : ERROR;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Word count and write address advance as the single WRITE cycle retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_lo <= '0;
            r_nwords <= '0;
            r_words  <= '0;
            r_addr   <= BASE_ADDR;
        end else begin
            if (w_start_load) begin
                r_words <= '0;
                r_addr  <= BASE_ADDR;
            end
            if (r_state == HDR0 && bus.in_valid) r_hdr_lo <= bus.in_data;
            if (r_state == HDR1 && bus.in_valid) r_nwords <= w_hdr_count;
            if (r_state == WRITE) begin
                r_words <= r_words + HDR_W'(1);
                r_addr  <= r_addr + ADDR_W'(ADDR_STEP);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xor <= '0;
        end else if (w_start_load) begin
            r_xor <= '0;
        end else if (w_byte_accept) begin
            r_xor <= r_xor ^ bus.in_data;
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = (r_state == WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_word;
    assign busy          = (r_state == HDR0) || (r_state == HDR1) || (r_state == LOAD) ||
                           (r_state == WRITE) || (r_state == CSUM);
    assign done          = (r_state == DONE);
    assign err           = (r_state == ERROR);
    assign cpu_hold      = (r_state != DONE);
    assign words_loaded  = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
    localparam int ADDR_W    = 32;
    localparam int MAX_WORDS = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycleCnt = 0;
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    int          wrCycle[$];
    logic [7:0]  dataBytes[$];
    logic [7:0]  txBytes[$];
    int          acceptCycles[$];
    int          lastAccept;
    int          gapWrites;
    bit          streamAborted;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // RAM side: record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wrAddr.push_back(bus.mem_addr);
            wrData.push_back(bus.mem_wdata);
            wrCycle.push_back(cycleCnt);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] model_word(input int i);
        return 32'(dataBytes[4*i]) + 32'(dataBytes[4*i+1]) * 32'd256 +
               32'(dataBytes[4*i+2]) * 32'd65536 + 32'(dataBytes[4*i+3]) * 32'd16777216;
    endfunction

    task automatic build_stream(input int n, input bit withCsum, input bit csumGood);
        logic [7:0] x;
        x = 8'h00;
        txBytes.delete();
        txBytes.push_back(n[7:0]);
        txBytes.push_back(n[15:8]);
        foreach (dataBytes[i]) begin
            txBytes.push_back(dataBytes[i]);
            x = x ^ dataBytes[i];
        end
        if (withCsum) txBytes.push_back(csumGood ? x : (x ^ 8'h07));
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        if (streamAborted) return;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            testsRun++;
            testsFailed++;
            streamAborted = 1'b1;
            $display("[TB] FAIL in_ready_timeout: in_ready=%b after 40 cycles, required 1", bus.in_ready);
        end
        @(negedge clk);
        lastAccept   = cycleCnt;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input int gapAt, input int gapLen, input bit randGaps,
                            output int duration, output bit finished);
        int t;
        int startCycle;
        t = 0;
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        acceptCycles.delete();
        streamAborted = 1'b0;
        gapWrites     = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        startCycle = cycleCnt;
        foreach (txBytes[i]) begin
            if (randGaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(txBytes[i]);
            acceptCycles.push_back(lastAccept);
            if (i == gapAt) begin
                repeat (gapLen) @(negedge clk);
                gapWrites = wrAddr.size();
            end
        end
        while (done !== 1'b1 && err !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        duration = cycleCnt - startCycle;
        finished = (t < 30) && !streamAborted;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        testsRun++;
        if ({bus.in_ready, bus.mem_we, busy, done, err, cpu_hold} !== 6'b000001) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: {rdy,we,busy,done,err,hold}=%b required 000001",
                     {bus.in_ready, bus.mem_we, busy, done, err, cpu_hold});
        end
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: addr=%h wdata=%h words=%0d required 0/0/0",
                     bus.mem_addr, bus.mem_wdata, words_loaded);
        end
        testsRun++;
        if ({bus.in_ready, busy, done, err, cpu_hold} !== 5'b00001) begin
            testsFailed++;
            $display("[TB] FAIL idle_flags: {rdy,busy,done,err,hold}=%b required 00001",
                     {bus.in_ready, busy, done, err, cpu_hold});
        end
    endtask

    task automatic load_two_words(input int gapAt, input int gapLen, output int dur);
        bit fin;
        dataBytes = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_stream(2, CSUM_ON, 1'b1);
        run_load(gapAt, gapLen, 1'b0, dur, fin);
        testsRun++;
        if (!fin) begin
            testsFailed++;
            $display("[TB] FAIL two_words_finish: load did not finish, required done");
        end
        testsRun++;
        if (wrAddr.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL two_words_count: %0d writes, required 2", wrAddr.size());
        end else if (wrAddr[0] !== 32'h0 || wrData[0] !== 32'h00500013 ||
                     wrAddr[1] !== 32'h4 || wrData[1] !== 32'h00100093) begin
            testsFailed++;
            $display("[TB] FAIL two_words_data: %h@%h %h@%h, required 00500013@0 00100093@4",
                     wrData[0], wrAddr[0], wrData[1], wrAddr[1]);
        end
        testsRun++;
        if (words_loaded !== 16'd2 || {done, err, cpu_hold, busy} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL two_words_status: words=%0d {done,err,hold,busy}=%b required 2/1000",
                     words_loaded, {done, err, cpu_hold, busy});
        end
    endtask

    int baseDuration;

    task automatic test_two_words();
        int dur;
        load_two_words(-1, 0, dur);
        baseDuration = dur;
        testsRun++;
        if (dur != 2 + 5 * 2 + int'(CSUM_ON)) begin
            testsFailed++;
            $display("[TB] FAIL two_words_duration: %0d cycles, required %0d", dur, 12 + int'(CSUM_ON));
        end
        testsRun++;
        if (wrCycle.size() < 1 || acceptCycles.size() < 6 || wrCycle[0] != acceptCycles[5]) begin
            testsFailed++;
            $display("[TB] FAIL write_latency: write cycle %0d, required %0d",
                     (wrCycle.size() > 0) ? wrCycle[0] : -1, (acceptCycles.size() > 5) ? acceptCycles[5] : -1);
        end
    endtask

    task automatic test_stall();
        int dur;
        load_two_words(3, 3, dur);
        testsRun++;
        if (gapWrites != 0) begin
            testsFailed++;
            $display("[TB] FAIL stall_no_write: %0d writes during gap, required 0", gapWrites);
        end
        testsRun++;
        if (dur != baseDuration + 3) begin
            testsFailed++;
            $display("[TB] FAIL stall_duration: %0d cycles, required %0d", dur, baseDuration + 3);
        end
    endtask

    task automatic test_header_overflow();
        int dur;
        bit fin;
        txBytes = {8'h01, 8'h04};
        run_load(-1, 0, 1'b0, dur, fin);
        repeat (10) @(negedge clk);
        testsRun++;
        if ({err, done, cpu_hold, bus.in_ready, busy} !== 5'b10100) begin
            testsFailed++;
            $display("[TB] FAIL overflow_status: {err,done,hold,rdy,busy}=%b required 10100",
                     {err, done, cpu_hold, bus.in_ready, busy});
        end
        testsRun++;
        if (wrAddr.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL overflow_writes: %0d writes, required 0", wrAddr.size());
        end
    endtask

    task automatic test_zero_count();
        int dur;
        bit fin;
        dataBytes.delete();
        build_stream(0, CSUM_ON, 1'b1);
        run_load(-1, 0, 1'b0, dur, fin);
        testsRun++;
        if (!fin || dur != 2 + int'(CSUM_ON) || {done, err, cpu_hold} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL zero_count_done: dur=%0d {done,err,hold}=%b required %0d/100",
                     dur, {done, err, cpu_hold}, 2 + int'(CSUM_ON));
        end
        testsRun++;
        if (wrAddr.size() != 0 || words_loaded !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL zero_count_writes: writes=%0d words=%0d required 0/0",
                     wrAddr.size(), words_loaded);
        end
    endtask

    task automatic test_reset_midload();
        int dur;
        bit fin;
        dataBytes.delete();
        for (int i = 0; i < 8; i++) dataBytes.push_back(8'($urandom_range(1, 255)));
        build_stream(2, CSUM_ON, 1'b1);
        streamAborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        testsRun++;
        if ({cpu_hold, busy, done} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL restart_hold: {hold,busy,done}=%b required 110", {cpu_hold, busy, done});
        end
        for (int i = 0; i < 6; i++) send_byte(txBytes[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        testsRun++;
        if (words_loaded !== 16'd1 || bus.mem_addr !== 32'h4 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL start_ignored: words=%0d addr=%h busy=%b required 1/4/1",
                     words_loaded, bus.mem_addr, busy);
        end
        for (int i = 6; i < 8; i++) send_byte(txBytes[i]);
        reset = 1'b1;
        #1;
        testsRun++;
        if ({bus.in_ready, bus.mem_we, busy, done, err, cpu_hold} !== 6'b000001) begin
            testsFailed++;
            $display("[TB] FAIL midload_reset_flags: {rdy,we,busy,done,err,hold}=%b required 000001",
                     {bus.in_ready, bus.mem_we, busy, done, err, cpu_hold});
        end
        testsRun++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL midload_reset_values: addr=%h wdata=%h words=%0d required 0/0/0",
                     bus.mem_addr, bus.mem_wdata, words_loaded);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dataBytes.delete();
        for (int i = 0; i < 4; i++) dataBytes.push_back(8'($urandom));
        build_stream(1, CSUM_ON, 1'b1);
        run_load(-1, 0, 1'b0, dur, fin);
        testsRun++;
        if (!fin || wrAddr.size() != 1 || wrAddr[0] !== 32'h0 || wrData[0] !== model_word(0) || done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_load: writes=%0d first=%h@%h done=%b required 1 write %h@0 done",
                     wrAddr.size(), (wrData.size() > 0) ? wrData[0] : 32'hx,
                     (wrAddr.size() > 0) ? wrAddr[0] : 32'hx, done, model_word(0));
        end
    endtask

    // Randomised loads, payload and idle gaps; expectations come from the byte list alone.
    task automatic test_random();
        int  dur;
        bit  fin;
        int  n;
        int  mism;
        bit  good;
        bit  expOk;
        for (int k = 0; k < 6; k++) begin
            n    = $urandom_range(1, 6);
            good = ($urandom_range(0, 3) != 0);
            dataBytes.delete();
            for (int i = 0; i < 4 * n; i++) dataBytes.push_back(8'($urandom));
            build_stream(n, CSUM_ON, good);
            run_load(-1, 0, 1'b1, dur, fin);
            expOk = !CSUM_ON || good;
            mism  = 0;
            if (wrAddr.size() != n) mism++;
            else for (int i = 0; i < n; i++)
                if (wrAddr[i] !== 32'(4 * i) || wrData[i] !== model_word(i)) mism++;
            testsRun++;
            if (mism != 0) begin
                testsFailed++;
                $display("[TB] FAIL rand_writes: load %0d had %0d bad/missing writes of %0d, required 0", k, mism, n);
            end
            testsRun++;
            if (!fin || {done, err, cpu_hold} !== (expOk ? 3'b100 : 3'b011) || words_loaded !== 16'(n)) begin
                testsFailed++;
                $display("[TB] FAIL rand_status: load %0d {done,err,hold}=%b words=%0d required %b/%0d",
                         k, {done, err, cpu_hold}, words_loaded, expOk ? 3'b100 : 3'b011, n);
            end
        end
    endtask

    task automatic test_max_words();
        int dur;
        bit fin;
        int mism;
        dataBytes.delete();
        for (int i = 0; i < 4 * MAX_WORDS; i++) dataBytes.push_back(8'($urandom));
        build_stream(MAX_WORDS, CSUM_ON, 1'b1);
        run_load(-1, 0, 1'b0, dur, fin);
        mism = 0;
        if (wrAddr.size() != MAX_WORDS) mism++;
        else for (int i = 0; i < MAX_WORDS; i++)
            if (wrAddr[i] !== 32'(4 * i) || wrData[i] !== model_word(i)) mism++;
        testsRun++;
        if (!fin || mism != 0 || words_loaded !== 16'(MAX_WORDS) || done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL max_words: bad=%0d writes=%0d words=%0d done=%b required 0/%0d/%0d/1",
                     mism, wrAddr.size(), words_loaded, done, MAX_WORDS, MAX_WORDS);
        end
        testsRun++;
        if (dur != 2 + 5 * MAX_WORDS + int'(CSUM_ON)) begin
            testsFailed++;
            $display("[TB] FAIL max_words_throughput: %0d cycles, required %0d",
                     dur, 2 + 5 * MAX_WORDS + int'(CSUM_ON));
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int dur;
        bit fin;
        txBytes = {8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
        run_load(-1, 0, 1'b0, dur, fin);
        testsRun++;
        if ({done, err, cpu_hold} !== 3'b100 || wrAddr.size() != 1) begin
            testsFailed++;
            $display("[TB] FAIL csum_good: {done,err,hold}=%b writes=%0d required 100/1",
                     {done, err, cpu_hold}, wrAddr.size());
        end
        txBytes = {8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h44};
        run_load(-1, 0, 1'b0, dur, fin);
        testsRun++;
        if ({done, err, cpu_hold} !== 3'b011 || wrAddr.size() != 1) begin
            testsFailed++;
            $display("[TB] FAIL csum_bad: {done,err,hold}=%b writes=%0d required 011/1",
                     {done, err, cpu_hold}, wrAddr.size());
        end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_two_words();
        test_stall();
        test_header_overflow();
        test_zero_count();
        test_reset_midload();
        test_random();
        test_max_words();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
